// File: rtl/y86_bus_pkg.sv
// Shared types and default sizing for the Y86 bus memory.
package y86_bus_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/y86_byte_ram.sv
// Byte-wide storage: four async read ports, a 4-byte little-endian write
// port with address wrap, and a single-byte loader write port.
module y86_byte_ram #(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic [3:0][ADDR_W-1:0] raddr,
  output logic [3:0][7:0]        rdata,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [31:0]            wdata,
  input  logic                   ld_we,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [7:0]             ld_data
);
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // The CPU and loader never write in the same cycle; CPU port wins anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++)
        mem[waddr + ADDR_W'(i)] <= wdata[8*i +: 8];
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rd
    assign rdata[g] = mem[raddr[g]];
  end
endmodule

// File: rtl/y86_bus_mem.sv
// CPU-facing byte memory with a boot loader: holds the CPU while an image
// streams in, then serves combinational reads and clocked writes.
module y86_bus_mem
  import y86_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      bus_A,
  input  logic             bus_RE,
  input  logic             bus_WE,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_hold,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic             err
);
  state_t                 state;
  logic [ADDR_W-1:0]      lp;
  logic [ADDR_W-1:0]      a;
  logic [3:0][ADDR_W-1:0] raddr;
  logic [3:0][7:0]        rbytes;
  logic                   in_range, run, rd_hit, wr_hit, ld_acc;

  assign a        = bus_A[ADDR_W-1:0];
  assign in_range = (bus_A[31:ADDR_W] == '0);
  assign run      = (state == RUN);
  assign rd_hit   = run && bus_RE && in_range;
  assign wr_hit   = run && bus_WE && in_range;
  assign ld_acc   = ld_valid && ld_ready;

  for (genvar g = 0; g < 4; g++) begin : g_addr
    assign raddr[g] = a + ADDR_W'(g);
  end

  y86_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .raddr   (raddr),
    .rdata   (rbytes),
    .we      (wr_hit && !rst),
    .waddr   (a),
    .wdata   (bus_wdata),
    .ld_we   (ld_acc && !rst),
    .ld_addr (lp),
    .ld_data (ld_byte)
  );

  // Read-before-write: a simultaneous write shows old contents this cycle.
  assign bus_rdata = (rd_hit && !rst) ? rbytes : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      lp       <= '0;
      ld_ready <= 1'b1;
      cpu_hold <= 1'b1;
      rd_count <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_acc) begin
            lp <= lp + 1'b1;
            if (lp == '1) err <= 1'b1;
            if (ld_last) begin
              state    <= RUN;
              ld_ready <= 1'b0;
              cpu_hold <= 1'b0;
            end
          end
        end
        RUN: begin
          if ((bus_RE || bus_WE) && !in_range) err <= 1'b1;
          if (bus_RE && bus_WE) err <= 1'b1;
          if (rd_hit && rd_count != '1) rd_count <= rd_count + 1'b1;
          if (wr_hit && wr_count != '1) wr_count <= wr_count + 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_y86_bus_mem.sv
// Directed scoreboard bench for y86_bus_mem (ADDR_W=10, CNT_W=16).
module tb_y86_bus_mem;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   bus_A, bus_wdata, bus_rdata;
  logic          bus_RE, bus_WE;
  logic          ld_valid, ld_last, ld_ready, cpu_hold, err;
  logic [7:0]    ld_byte;
  logic [CW-1:0] rd_count, wr_count;

  y86_bus_mem #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_hold(cpu_hold), .rd_count(rd_count), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m [MSZ];
  int         lp_m;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] rd32(input int ad);
    return {m[(ad+3)%MSZ], m[(ad+2)%MSZ], m[(ad+1)%MSZ], m[ad%MSZ]};
  endfunction

  task automatic mwr(input int ad, input logic [31:0] d);
    for (int i = 0; i < 4; i++) m[(ad+i)%MSZ] = d[8*i +: 8];
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    tick();
    m[lp_m%MSZ] = b; lp_m++;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; lp_m = 0;
  endtask

  task automatic read_chk(input string tag, input int ad);
    bus_RE = 1'b1; bus_A = ad;
    push(tag, rd32(ad));
    #1 chk(bus_rdata);
    bus_RE = 1'b0;
  endtask

  task automatic write(input int ad, input logic [31:0] d);
    bus_WE = 1'b1; bus_A = ad; bus_wdata = d;
    tick();
    bus_WE = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_A = 0; bus_RE = 0; bus_WE = 0; bus_wdata = 0;
    ld_valid = 0; ld_byte = 0; ld_last = 0; lp_m = 0;
    rst = 1'b1; tick(); tick();
    bus_RE = 1'b1;
    push("rst_rdata", 0);      #1 chk(bus_rdata);
    push("rst_ld_ready", 1);   chk(ld_ready);
    push("rst_cpu_hold", 1);   chk(cpu_hold);
    push("rst_rd_count", 0);   chk(rd_count);
    push("rst_wr_count", 0);   chk(wr_count);
    push("rst_err", 0);        chk(err);
    bus_RE = 1'b0; rst = 1'b0;

    // Image 1, with CPU strobes (one out of range) during LOAD
    bus_RE = 1'b1; bus_WE = 1'b1; bus_A = 32'h400;
    push("load_rdata_zero", 0); #1 chk(bus_rdata);
    load_byte(8'hC0, 0);
    bus_RE = 1'b0; bus_WE = 1'b0;
    push("load_strobe_no_err", 0); chk(err);
    load_byte(8'hC1, 0); load_byte(8'hC2, 0); load_byte(8'h00, 1);
    push("run_cpu_hold", 0); chk(cpu_hold);
    push("run_ld_ready", 0); chk(ld_ready);
    read_chk("img1_rd0", 0);

    // Abort a load after 2 of 4 bytes; coincident loader byte is dropped
    do_reset();
    load_byte(8'hD0, 0); load_byte(8'hD1, 0);
    rst = 1'b1; ld_valid = 1'b1; ld_byte = 8'hEE;
    tick();
    rst = 1'b0; ld_valid = 1'b0; lp_m = 0;
    push("abort_ld_ready", 1); chk(ld_ready);
    push("abort_cpu_hold", 1); chk(cpu_hold);
    push("abort_err", 0);      chk(err);
    load_byte(8'h8B, 1);
    read_chk("abort_persist_rd0", 0);

    // Boot image 8B 4E 04
    do_reset();
    load_byte(8'h8B, 0); load_byte(8'h4E, 0);
    push("boot_hold_before_last", 1); chk(cpu_hold);
    load_byte(8'h04, 1);
    push("boot_hold_after_last", 0); chk(cpu_hold);
    push("boot_rd0", 32'h00044E8B);
    bus_RE = 1'b1; bus_A = 0; #1 chk(bus_rdata); bus_RE = 1'b0;

    // Wrapping write at top of memory
    write(32'h3FE, 32'hAABBCCDD); mwr(32'h3FE, 32'hAABBCCDD);
    push("wrap_wr_count", 1); chk(wr_count);
    push("wrap_err", 0);      chk(err);
    read_chk("wrap_rd3fe", 32'h3FE);
    read_chk("wrap_rd0", 0);

    // Simultaneous read and write
    write(32'h10, 32'h11223344); mwr(32'h10, 32'h11223344);
    bus_RE = 1'b1; bus_WE = 1'b1; bus_A = 32'h10; bus_wdata = 32'h55667788;
    push("rw_old_data", 32'h11223344); #1 chk(bus_rdata);
    tick(); mwr(32'h10, 32'h55667788);
    bus_RE = 1'b0; bus_WE = 1'b0;
    push("rw_err", 1);      chk(err);
    push("rw_wr_count", 3); chk(wr_count);
    push("rw_rd_count", 1); chk(rd_count);
    read_chk("rw_new_data", 32'h10);

    // Out-of-range write is suppressed
    write(32'h410, 32'hFFFFFFFF);
    push("oor_wr_count", 3); chk(wr_count);
    read_chk("oor_no_write", 32'h10);

    // Out-of-range read on a clean err flag
    do_reset();
    push("rerst_err", 0); chk(err);
    load_byte(8'h8B, 1);
    bus_RE = 1'b1; bus_A = 32'h400;
    push("oor_rdata", 0); #1 chk(bus_rdata);
    tick(); bus_RE = 1'b0;
    push("oor_rd_err", 1);   chk(err);
    push("oor_rd_count", 0); chk(rd_count);
    repeat (10) tick();
    push("err_sticky", 1); chk(err);

    // Load-pointer wrap
    do_reset();
    for (int i = 0; i < MSZ-1; i++) load_byte(8'((i*7+3) & 8'hFF), 0);
    push("lp_pre_wrap_err", 0); chk(err);
    load_byte(8'hA5, 0);
    push("lp_wrap_err", 1); chk(err);
    load_byte(8'h5A, 1);
    push("lp_wrap_run", 0); chk(cpu_hold);
    read_chk("lp_wrap_rd3fe", 32'h3FE);

    // Read-counter saturation
    do_reset();
    load_byte(8'h01, 1);
    bus_RE = 1'b1; bus_A = 32'h20;
    repeat (3) tick();
    push("rd_count_3", 3); chk(rd_count);
    repeat ((1 << CW) + 2) tick();
    bus_RE = 1'b0;
    push("rd_count_sat", 32'h0000FFFF); chk(rd_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/y86_bus_mem.md
Y86_BUS_MEM -- requirements
Module: y86_bus_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving byte-address width (memory size 2^ADDR_W bytes).
REQ-002 SHALL have parameter CNT_W, default 16, giving access-counter width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bus_A  input  32  byte address driven by the CPU.
REQ-006 bus_RE  input  1  CPU read strobe.
REQ-007 bus_WE  input  1  CPU write strobe.
REQ-008 bus_wdata  input  32  CPU write data (the CPU's bus_out).
REQ-009 bus_rdata  output  32  read data to the CPU (the CPU's bus_in).
REQ-010 ld_valid  input  1  loader byte valid.
REQ-011 ld_byte  input  8  loader byte.
REQ-012 ld_last  input  1  marks final loader byte.
REQ-013 ld_ready  output  1  loader byte accepted when ld_valid and ld_ready are both high.
REQ-014 cpu_hold  output  1  high while the CPU must be held in reset (image not loaded).
REQ-015 rd_count, wr_count  output  CNT_W  saturating counts of serviced reads and writes.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 SHALL implement a two-state FSM, LOAD and RUN; LOAD is entered on reset.
REQ-018 In LOAD: ld_ready=1 and cpu_hold=1; each accepted byte SHALL be written to the byte at load pointer lp, and lp SHALL increment, starting at 0 after reset.
REQ-019 Acceptance with ld_last=1 SHALL write that byte and transition to RUN on the same edge.
REQ-020 A load-pointer wrap from 2^ADDR_W-1 to 0 SHALL set err; loading continues at 0.
REQ-021 In RUN: ld_ready=0, cpu_hold=0, and loader inputs are ignored.
REQ-022 Read is combinational, with zero latency: when bus_RE=1 in RUN and bus_A < 2^ADDR_W, bus_rdata = {m[a+3],m[a+2],m[a+1],m[a]} (little-endian, unaligned allowed, byte indices modulo 2^ADDR_W).
REQ-023 bus_rdata SHALL be 0 when bus_RE=0, in LOAD, or when bus_A >= 2^ADDR_W.
REQ-024 Write: on the edge where bus_WE=1 in RUN and bus_A < 2^ADDR_W, bytes a..a+3 (modulo 2^ADDR_W) SHALL receive bus_wdata[7:0]..[31:24].
REQ-025 bus_A >= 2^ADDR_W with bus_RE or bus_WE high in RUN SHALL set err and suppress the write.
REQ-026 bus_RE and bus_WE both high SHALL set err and perform the write; bus_rdata in that cycle shows pre-write contents.
REQ-027 Strobes in LOAD SHALL be ignored and SHALL NOT set err.
REQ-028 rd_count and wr_count SHALL increment by 1 per clock in RUN with the respective strobe high and the address in range, saturating at all-ones.
REQ-029 err, once set, SHALL stay high until rst.

Reset
REQ-030 rst SHALL force: state LOAD, lp=0, ld_ready=1, cpu_hold=1, rd_count=0, wr_count=0, err=0; bus_rdata=0.
REQ-031 Memory contents SHALL NOT be cleared by rst.
REQ-032 rst asserted mid-load or mid-run SHALL abandon the operation; a write or load coincident with rst SHALL be suppressed.

Structure
REQ-033 Shared package y86_bus_pkg SHALL hold the FSM state enum (LOAD, RUN) and default ADDR_W/CNT_W constants.
REQ-034 Byte storage SHALL be one sub-module, y86_byte_ram: 2^ADDR_W x 8, four combinational read ports, and one 4-byte write port plus one 1-byte write port (loader).

Verification
REQ-035 Load bytes 0x8B,0x4E,0x04 with ld_last on the third -> cpu_hold falls the next cycle; bus_RE=1, bus_A=0 -> bus_rdata=0x00044E8B.
REQ-036 RUN, bus_WE=1, bus_A=0x3FE, bus_wdata=0xAABBCCDD (ADDR_W=10) -> m[0x3FE]=DD, m[0x3FF]=CC, m[0]=BB, m[1]=AA; read at 0x3FE returns 0xAABBCCDD; wr_count=1.
REQ-037 RUN, bus_RE=1, bus_A=0x400 -> bus_rdata=0 and err=1 next cycle; rd_count unchanged; err stays 1 after 10 idle cycles.
REQ-038 Hold bus_RE=1 in range for 2^CNT_W+5 cycles -> rd_count saturates at 0xFFFF.
REQ-039 Assert rst after 2 of 4 load bytes -> state LOAD, lp=0, err=0, and previously loaded bytes persist; reload starts at address 0.
REQ-040 bus_RE=bus_WE=1 at address 0x10 holding 0x11223344, bus_wdata=0x55667788 -> bus_rdata=0x11223344 that cycle, memory=0x55667788 after the edge, err=1.
